// File: rtl/lsu_pkg.sv
// lsu_pkg: RV32I width codes, FSM state encoding and request-decode helpers
// shared by the load/store unit. Used with the LSU_MISALIGN_TRAP_EN build option.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Width codes that have no meaning for the given direction.
  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) return !(funct3 inside {F3_B, F3_H, F3_W});
    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

  // Address bits below the access size are non-zero.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic m;
    case (funct3[1:0])
      2'b01:   m = addr_lo[0];
      2'b10:   m = |addr_lo;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Stores narrower than a word need the old word read before writing.
  function automatic logic needs_merge(input logic we, input logic [2:0] funct3);
    return we && (funct3 != F3_W);
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: core-side request/response channel of the load/store unit.
// master = core, slave = lsu_mem_ctrl.
interface lsu_mem_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational lane logic -- extracts and extends load data
// from a memory word, and merges byte/halfword store data into a memory word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  // Halfword lane uses addr[1] only, so an odd halfword address is force-aligned.
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding RV32I load/store controller in front of a
// word-wide data memory. Build option: LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module lsu_mem_ctrl
  import lsu_pkg::*;
(
  input  logic         CLK,
  input  logic         rst,
  lsu_mem_ctrl_if.slave bus,
  output logic         mem_WE,
  output logic [31:0]  mem_A,
  output logic [31:0]  mem_WD,
  input  logic [31:0]  mem_RD
);

  state_e      state;
  state_e      state_nxt;

  logic        ready;
  logic        accept;
  logic        req_err;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept = bus.req_valid && ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = funct3_illegal(bus.req_we, bus.req_funct3)
                 | misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign req_err = funct3_illegal(bus.req_we, bus.req_funct3);
`endif

  lsu_byte_lane u_byte_lane (
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .word       (mem_RD),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Handshake and write strobe are pure state decodes, so an asynchronous
  // reset in WR removes mem_WE without waiting for a clock edge.
  always_comb begin
    state_nxt      = state;
    ready          = 1'b0;
    bus.resp_valid = 1'b0;
    mem_WE         = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                                    state_nxt = S_RESP;
          else if (needs_merge(bus.req_we, bus.req_funct3) || !bus.req_we)
                                                          state_nxt = S_RD;
          else                                            state_nxt = S_WR;
        end
      end
      S_RD:    state_nxt = we_q ? S_WR : S_RESP;
      S_WR: begin
        mem_WE    = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready = ready;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      we_q           <= 1'b0;
      funct3_q       <= 3'd0;
      addr_lo_q      <= 2'd0;
      wdata_q        <= 32'd0;
      mem_A          <= 32'd0;
      mem_WD         <= 32'd0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q      <= bus.req_we;
            funct3_q  <= bus.req_funct3;
            addr_lo_q <= bus.req_addr[1:0];
            wdata_q   <= bus.req_wdata;
            if (req_err) begin
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'd0;
            end else begin
              mem_A <= {2'b00, bus.req_addr[31:2]};
              if (bus.req_we && !needs_merge(bus.req_we, bus.req_funct3))
                mem_WD <= bus.req_wdata;
            end
          end
        end
        S_RD: begin
          if (we_q) begin
            mem_WD <= store_word;
          end else begin
            bus.resp_rdata <= load_data;
            bus.resp_err   <= 1'b0;
          end
        end
        S_WR: begin
          bus.resp_rdata <= 32'd0;
          bus.resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The write strobe and the completion pulse never stretch beyond one cycle.
  a_we_single: assert property (@(posedge CLK) disable iff (!rst) mem_WE |=> !mem_WE);
  a_resp_single: assert property (@(posedge CLK) disable iff (!rst) bus.resp_valid |=> !bus.resp_valid);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a word-array data
// memory and an arithmetic reference model of RV32I load/store semantics.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  resp_t       exp_q [$];
  wr_t         wr_q  [$];

  int checks     = 0;
  int failures   = 0;
  int cycle      = 0;
  int resp_count = 0;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl dut (
    .CLK    (CLK),
    .rst    (rst),
    .bus    (bus),
    .mem_WE (mem_WE),
    .mem_A  (mem_A),
    .mem_WD (mem_WD),
    .mem_RD (mem_RD)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  assign mem_RD = mem[mem_A[3:0]];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    forever begin
      @(posedge CLK);
      if (mem_WE) mem[mem_A[3:0]] <= mem_WD;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    resp_t e;
    wr_t   w;
    check("req_ready", 32'(bus.req_ready), 32'(exp_q.size() == 0));
    if (bus.resp_valid) begin
      resp_count++;
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_err", 32'(bus.resp_err), 32'(e.err));
        check("resp_latency", cycle - e.acc + 1, e.lat);
      end
    end
    if (mem_WE) begin
      if (wr_q.size() == 0) begin
        check("write_unexpected", 32'(mem_WE), 32'd0);
      end else begin
        w = wr_q.pop_front();
        check("mem_A", mem_A, w.idx);
        check("mem_WD", mem_WD, w.data);
      end
    end
  end

  // Presents one request, waits for acceptance, then records what the memory
  // and the core should see according to the RV32I load/store rules.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int waited);
    resp_t       e;
    wr_t         w;
    logic        err;
    logic [31:0] old_word;
    logic [31:0] new_word;
    logic [7:0]  b;
    logic [15:0] h;
    int          idx;
    int          sh_b;
    int          sh_h;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waited = 0;
    while (!bus.req_ready && waited < 64) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    @(posedge CLK);
    #1;
    err = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) err = 1'b1;
    if (f3 == 3'd2 && (addr % 4 != 0)) err = 1'b1;
`endif
    idx      = int'((addr / 4) % 16);
    old_word = ref_mem[idx];
    sh_b     = 8 * int'(addr % 4);
    sh_h     = 16 * int'((addr / 2) % 2);
    b        = 8'(old_word >> sh_b);
    h        = 16'(old_word >> sh_h);
    e.acc    = cycle;
    e.err    = err;
    e.rdata  = 32'd0;
    if (err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      case (f3)
        3'd0:    e.rdata = {{24{b[7]}}, b};
        3'd4:    e.rdata = {24'd0, b};
        3'd1:    e.rdata = {{16{h[15]}}, h};
        3'd5:    e.rdata = {16'd0, h};
        default: e.rdata = old_word;
      endcase
    end else begin
      case (f3)
        3'd0:    new_word = (old_word & ~(32'hFF << sh_b)) | ((wdata & 32'hFF) << sh_b);
        3'd1:    new_word = (old_word & ~(32'hFFFF << sh_h)) | ((wdata & 32'hFFFF) << sh_h);
        default: new_word = wdata;
      endcase
      e.lat        = (f3 == 3'd2) ? 2 : 3;
      ref_mem[idx] = new_word;
      w.idx        = addr / 4;
      w.data       = new_word;
      wr_q.push_back(w);
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          waited;
    int          rc0;
    logic [31:0] old;
    resp_t       dummy;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;

    #2 rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_WE", 32'(mem_WE), 32'd0);
    check("rst_mem_A", mem_A, 32'd0);
    check("rst_mem_WD", mem_WD, 32'd0);

    @(negedge CLK);
    rst = 1'b1;
    issue(1'b1, F3_W, 32'h8, 32'hDEADBEEF, waited);
    check("first_accept_after_reset", waited, 0);
    bus.req_valid = 1'b0;
    wait_idle();

    issue(1'b0, F3_B, 32'hB, 32'd0, waited);
    issue(1'b0, F3_BU, 32'hB, 32'd0, waited);
    issue(1'b0, F3_HU, 32'h8, 32'd0, waited);
    issue(1'b1, F3_B, 32'h9, 32'h12, waited);
    issue(1'b0, F3_W, 32'h6, 32'd0, waited);
    issue(1'b0, 3'b011, 32'h4, 32'd0, waited);
    issue(1'b1, 3'b100, 32'h4, 32'h55, waited);
    bus.req_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 16; i++) issue(1'b1, F3_W, 32'(i * 4), $urandom(), waited);
    bus.req_valid = 1'b0;
    wait_idle();

    // Reset during the write cycle of a halfword store must abort the write.
    old            = ref_mem[3];
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'hE;
    bus.req_wdata  = ~old;
    @(posedge CLK);
    #1;
    dummy = '{rdata: 32'd0, err: 1'b0, lat: 3, acc: cycle};
    exp_q.push_back(dummy);
    bus.req_valid = 1'b0;
    @(posedge CLK);
    #1;
    check("sh_wr_strobe", 32'(mem_WE), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_mem_WE", 32'(mem_WE), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mid_rst_mem_A", mem_A, 32'd0);
    check("mid_rst_mem_WD", mem_WD, 32'd0);
    @(negedge CLK);
    rst = 1'b1;
    check("mid_rst_word_kept", mem[3], old);
    issue(1'b0, F3_W, 32'hC, 32'd0, waited);
    check("accept_after_mid_rst", waited, 0);
    bus.req_valid = 1'b0;
    wait_idle();

    rc0 = resp_count;
    issue(1'b0, F3_W, 32'h10, 32'd0, waited);
    issue(1'b0, F3_H, 32'h22, 32'd0, waited);
    issue(1'b0, F3_BU, 32'h3D, 32'd0, waited);
    bus.req_valid = 1'b0;
    wait_idle();
    check("b2b_resp_count", resp_count - rc0, 3);

    for (int n = 0; n < 250; n++) begin
      logic       rwe;
      logic [2:0] rf3;
      rwe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rf3 = 3'($urandom_range(0, 7));
      end else if (rwe) begin
        rf3 = 3'($urandom_range(0, 2));
      end else begin
        rf3 = 3'($urandom_range(0, 4));
        if (rf3 > 3'd2) rf3 = rf3 + 3'd1;
      end
      issue(rwe, rf3, $urandom(), $urandom(), waited);
      if ($urandom_range(0, 1) == 1) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge CLK);
          #1;
        end
      end
    end
    bus.req_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
